// File: rtl/wb_sdram_arbiter_if.sv
// Wishbone B3 bus bundle shared by the arbiter's two master ports and its SDRAM slave port.
// "master" is the initiator view, "slave" the responder view.
interface wb_sdram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack;
  logic            err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_sdram_arbiter.sv
// Two-master round-robin Wishbone B3 arbiter in front of the SDRAM controller port.
// Define WB_SDRAM_ARBITER_TIMEOUT_EN to add the stalled-strobe watchdog (TIMEOUT_CYCLES).
module wb_sdram_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  wb_sdram_arbiter_if.slave        m0_io,
  wb_sdram_arbiter_if.slave        m1_io,
  wb_sdram_arbiter_if.master       s_io,
  output logic [1:0]               gnt_o
);

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  logic [1:0]      grant_q, grant_d;
  logic            last_q, last_d;
  logic            release_now;
  logic            aborted;
  logic            to_fire;
  logic            own_cyc, own_stb, fwd_stb;
  logic [AW-1:0]   adr_mux;
  logic [DW-1:0]   dat_mux;
  logic [DW/8-1:0] sel_mux;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_sdram_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      grant_q <= GNT_NONE;
      last_q  <= 1'b1;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // A release re-arbitrates in the same edge so a waiting master is handed over after one idle cycle.
  always_comb begin
    grant_d     = grant_q;
    last_d      = last_q;
    release_now = 1'b0;
    if (grant_q == GNT_M0 && !m0_io.cyc) begin
      last_d      = 1'b0;
      release_now = 1'b1;
    end else if (grant_q == GNT_M1 && !m1_io.cyc) begin
      last_d      = 1'b1;
      release_now = 1'b1;
    end
    if (grant_q == GNT_NONE || release_now) begin
      unique case ({m1_io.cyc, m0_io.cyc})
        2'b01:   grant_d = GNT_M0;
        2'b10:   grant_d = GNT_M1;
        2'b11:   grant_d = last_d ? GNT_M0 : GNT_M1;
        default: grant_d = GNT_NONE;
      endcase
    end
  end

  always_comb begin
    adr_mux     = '0;
    dat_mux     = '0;
    sel_mux     = '0;
    s_io.we     = 1'b0;
    s_io.cti    = '0;
    s_io.bte    = '0;
    own_cyc     = 1'b0;
    own_stb     = 1'b0;
    m0_io.dat_r = '0;
    m0_io.ack   = 1'b0;
    m0_io.err   = 1'b0;
    m1_io.dat_r = '0;
    m1_io.ack   = 1'b0;
    m1_io.err   = 1'b0;
    if (grant_q == GNT_M0) begin
      adr_mux     = m0_io.adr;
      dat_mux     = m0_io.dat_w;
      sel_mux     = m0_io.sel;
      s_io.we     = m0_io.we;
      s_io.cti    = m0_io.cti;
      s_io.bte    = m0_io.bte;
      own_cyc     = m0_io.cyc;
      own_stb     = m0_io.stb;
      m0_io.dat_r = s_io.dat_r;
      m0_io.ack   = s_io.ack & ~aborted;
      m0_io.err   = (s_io.err & ~aborted) | to_fire;
    end else if (grant_q == GNT_M1) begin
      adr_mux     = m1_io.adr;
      dat_mux     = m1_io.dat_w;
      sel_mux     = m1_io.sel;
      s_io.we     = m1_io.we;
      s_io.cti    = m1_io.cti;
      s_io.bte    = m1_io.bte;
      own_cyc     = m1_io.cyc;
      own_stb     = m1_io.stb;
      m1_io.dat_r = s_io.dat_r;
      m1_io.ack   = s_io.ack & ~aborted;
      m1_io.err   = (s_io.err & ~aborted) | to_fire;
    end
  end

  assign fwd_stb    = own_stb & ~aborted;
  assign s_io.cyc   = own_cyc & ~aborted;
  assign s_io.stb   = fwd_stb;
  assign s_io.adr   = adr_mux;
  assign s_io.dat_w = dat_mux;
  assign s_io.sel   = sel_mux;
  assign gnt_o      = grant_q;

`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic        stall;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  // Once fired, the bus stays masked until the owner gives up cyc and the grant moves.
  always_comb begin
    cnt_d   = cnt_q;
    abort_d = abort_q;
    if (grant_d != grant_q) begin
      cnt_d   = '0;
      abort_d = 1'b0;
    end else if (s_io.ack || s_io.err) begin
      cnt_d = '0;
    end else if (stall) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (to_fire) abort_d = 1'b1;
  end

  assign stall   = fwd_stb & ~s_io.ack & ~s_io.err;
  assign to_fire = stall & (cnt_q == TO_LAST);
  assign aborted = abort_q;
`else
  assign aborted = 1'b0;
  assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Scoreboard bench for wb_sdram_arbiter: masters push expected responses, a monitor pops on ack/err.
// The watchdog scenario runs only when WB_SDRAM_ARBITER_TIMEOUT_EN is defined.
module tb_wb_sdram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] gnt;

  always #5 clk = ~clk;

  wb_sdram_arbiter_if #(.AW(32), .DW(32)) m0_if ();
  wb_sdram_arbiter_if #(.AW(32), .DW(32)) m1_if ();
  wb_sdram_arbiter_if #(.AW(32), .DW(32)) s_if ();

  wb_sdram_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0_io    (m0_if),
    .m1_io    (m1_if),
    .s_io     (s_if),
    .gnt_o    (gnt)
  );

  logic [31:0] t_adr [2];
  logic [31:0] t_dat [2];
  logic [3:0]  t_sel [2];
  logic        t_we  [2];
  logic        t_cyc [2];
  logic        t_stb [2];
  logic [2:0]  t_cti [2];
  logic [1:0]  t_bte [2];
  logic        ack_w [2];
  logic        err_w [2];
  logic [31:0] rdat_w [2];

  assign m0_if.adr = t_adr[0];  assign m1_if.adr = t_adr[1];
  assign m0_if.dat_w = t_dat[0]; assign m1_if.dat_w = t_dat[1];
  assign m0_if.sel = t_sel[0];  assign m1_if.sel = t_sel[1];
  assign m0_if.we  = t_we[0];   assign m1_if.we  = t_we[1];
  assign m0_if.cyc = t_cyc[0];  assign m1_if.cyc = t_cyc[1];
  assign m0_if.stb = t_stb[0];  assign m1_if.stb = t_stb[1];
  assign m0_if.cti = t_cti[0];  assign m1_if.cti = t_cti[1];
  assign m0_if.bte = t_bte[0];  assign m1_if.bte = t_bte[1];
  assign ack_w[0] = m0_if.ack;  assign ack_w[1] = m1_if.ack;
  assign err_w[0] = m0_if.err;  assign err_w[1] = m1_if.err;
  assign rdat_w[0] = m0_if.dat_r; assign rdat_w[1] = m1_if.dat_r;

  int n_pass  = 0;
  int n_total = 0;
  int slv_lat = 3;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : ~a;
  endfunction

  function automatic logic [31:0] wr_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Slave model: ack after slv_lat strobed cycles (0 = never), one-cycle ack pulses.
  initial begin
    int cnt;
    cnt = 0;
    s_if.ack = 1'b0;
    s_if.err = 1'b0;
    s_if.dat_r = '0;
    forever begin
      @(posedge clk);
      #2;
      if (s_if.ack) begin
        s_if.ack = 1'b0;
        s_if.dat_r = '0;
        cnt = 0;
      end else if (s_if.cyc && s_if.stb && slv_lat > 0) begin
        cnt++;
        if (cnt >= slv_lat) begin
          s_if.ack = 1'b1;
          s_if.dat_r = s_if.we ? 32'h0 : rd_fn(s_if.adr);
          if (s_if.we) check("slave_wdata", {1'b0, s_if.dat_w}, {1'b0, wr_fn(s_if.adr)});
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every ack/err presented to a master consumes one expected response.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (ack_w[m] || err_w[m]) begin
          if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            check($sformatf("m%0d_unexpected_resp", m), {err_w[m], rdat_w[m]}, 33'h0);
          end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("m%0d_resp", m), {err_w[m], rdat_w[m]}, e);
          end
        end
      end
    end
  end

  task automatic bus_cycle(input int m, input int nb, input logic we, input logic [31:0] base,
                           input logic [2:0] cti, input int gap);
    logic [31:0] a;
    int n;
    t_cyc[m] = 1'b1;
    for (int i = 0; i < nb; i++) begin
      a = base + 32'(4 * i);
      t_adr[m] = a;
      t_we[m]  = we;
      t_dat[m] = wr_fn(a);
      t_sel[m] = 4'hF;
      t_bte[m] = 2'b00;
      t_cti[m] = (cti == 3'b010 && i == nb - 1) ? 3'b111 : cti;
      t_stb[m] = 1'b1;
      if (m == 0) q0.push_back(we ? 33'h0 : {1'b0, rd_fn(a)});
      else        q1.push_back(we ? 33'h0 : {1'b0, rd_fn(a)});
      n = 0;
      forever begin
        @(negedge clk);
        if (ack_w[m] || err_w[m]) break;
        n++;
        if (n > 200) begin
          check($sformatf("m%0d_ack_timeout", m), 33'h0, 33'h1);
          break;
        end
      end
      sync();
      t_stb[m] = 1'b0;
      repeat (gap) sync();
    end
    t_cyc[m] = 1'b0;
    t_stb[m] = 1'b0;
    t_cti[m] = 3'b000;
  endtask

  // Owner must keep the grant for its whole cycle, then one idle bus cycle, then the other master.
  task automatic watch_owner(input int own, input logic [1:0] g_own, input logic [1:0] g_next,
                             input string nm);
    int bad;
    int n;
    bad = 0;
    n = 0;
    @(negedge clk);
    while (t_cyc[own] && n < 500) begin
      @(negedge clk);
      if (t_cyc[own] && gnt !== g_own) bad++;
      n++;
    end
    check({nm, "_hold"}, 33'(bad), 33'h0);
    check({nm, "_gap"}, {30'h0, gnt, s_if.cyc}, {30'h0, g_own, 1'b0});
    @(negedge clk);
    check({nm, "_handover"}, {31'h0, gnt}, {31'h0, g_next});
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int n;
    for (int m = 0; m < 2; m++) begin
      t_adr[m] = '0; t_dat[m] = '0; t_sel[m] = '0; t_we[m] = 1'b0;
      t_cyc[m] = 1'b0; t_stb[m] = 1'b0; t_cti[m] = '0; t_bte[m] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {24'h0, gnt, s_if.cyc, s_if.stb, s_if.we, ack_w[0], err_w[0], ack_w[1], err_w[1]}, 33'h0);
    check("reset_s_adr", {1'b0, s_if.adr}, 33'h0);
    #2 rst = 1'b0;

    // Single m0 read with 1-cycle arbitration latency; m1 stays quiet.
    sync();
    fork
      bus_cycle(0, 1, 1'b0, 32'h0000_0100, 3'b000, 0);
      begin
        @(negedge clk);
        check("arb_lat_before", {32'h0, s_if.cyc}, 33'h0);
        @(negedge clk);
        check("arb_lat_after", {30'h0, gnt, s_if.cyc}, {30'h0, 2'b01, 1'b1});
        n = 0;
        while (!ack_w[0] && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("m1_quiet", {ack_w[1], err_w[1], rdat_w[1]}, 33'h0);
      end
    join
    repeat (2) sync();

    // Simultaneous requests after reset: m0 first, then m1, then m0 again.
    do_reset();
    sync();
    fork
      bus_cycle(0, 1, 1'b0, 32'h0000_0600, 3'b000, 0);
      bus_cycle(1, 1, 1'b0, 32'h0000_0700, 3'b000, 0);
      watch_owner(0, 2'b01, 2'b10, "rr_first");
    join
    repeat (2) sync();
    fork
      bus_cycle(0, 1, 1'b1, 32'h0000_0610, 3'b000, 0);
      bus_cycle(1, 1, 1'b1, 32'h0000_0710, 3'b000, 0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("rr_second", {31'h0, gnt}, {31'h0, 2'b01});
      end
    join
    repeat (2) sync();

    // m0 8-beat incrementing burst, m1 requests mid-burst.
    sync();
    fork
      bus_cycle(0, 8, 1'b0, 32'h0000_1000, 3'b010, 0);
      begin
        repeat (4) sync();
        bus_cycle(1, 1, 1'b1, 32'h0000_1800, 3'b000, 0);
      end
      watch_owner(0, 2'b01, 2'b10, "burst");
    join
    repeat (2) sync();

    // m1 writes with 5-cycle strobe gaps, m0 waiting the whole time.
    sync();
    fork
      bus_cycle(1, 3, 1'b1, 32'h0000_2000, 3'b000, 5);
      begin
        repeat (2) sync();
        bus_cycle(0, 1, 1'b0, 32'h0000_0500, 3'b000, 0);
      end
      watch_owner(1, 2'b10, 2'b01, "stb_gap");
    join
    repeat (2) sync();

    // Async reset while m1 owns the bus; m0 has priority afterwards.
    sync();
    fork
      bus_cycle(1, 4, 1'b0, 32'h0000_3000, 3'b010, 0);
      begin
        repeat (3) sync();
        bus_cycle(0, 1, 1'b0, 32'h0000_0400, 3'b000, 0);
      end
      begin
        repeat (5) @(negedge clk);
        check("pre_rst_owner", {30'h0, gnt, s_if.cyc}, {30'h0, 2'b10, 1'b1});
        #2 rst = 1'b1;
        #1;
        check("async_rst_clear", {30'h0, gnt, s_if.cyc}, 33'h0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("prio_after_rst", {31'h0, gnt}, {31'h0, 2'b01});
      end
    join
    repeat (2) sync();

`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
    // Stalled slave: error on the 16th stalled cycle, bus masked, then handover to m1.
    begin
      int bad_err;
      int bad_stb;
      bad_err = 0;
      bad_stb = 0;
      do_reset();
      slv_lat = 0;
      sync();
      t_adr[0] = 32'h0000_0200; t_we[0] = 1'b0; t_sel[0] = 4'hF; t_cti[0] = 3'b000;
      t_cyc[0] = 1'b1; t_stb[0] = 1'b1;
      q0.push_back(33'h1_0000_0000);
      t_adr[1] = 32'h0000_0900; t_we[1] = 1'b0; t_sel[1] = 4'hF; t_cti[1] = 3'b000;
      t_cyc[1] = 1'b1; t_stb[1] = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (err_w[0] !== (k == 16)) bad_err++;
        if (s_if.stb !== (k <= 16)) bad_stb++;
      end
      check("wdog_err_pulse", 33'(bad_err), 33'h0);
      check("wdog_stb_mask", 33'(bad_stb), 33'h0);
      sync();
      t_cyc[0] = 1'b0;
      t_stb[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("wdog_handover", {31'h0, gnt}, {31'h0, 2'b10});
      sync();
      t_cyc[1] = 1'b0;
      t_stb[1] = 1'b0;
      slv_lat = 3;
      repeat (3) sync();
    end
`endif

    repeat (4) sync();
    check("q0_drained", 33'(q0.size()), 33'h0);
    check("q1_drained", 33'(q1.size()), 33'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "tb_wb_sdram_arbiter timed out");
  end

endmodule
